// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the requester-side and TX-core-side signals of uart_tx_arbiter.
// Ports  : req/req_data/req_last/ack/grant (requesters), tx_start/tx_din/tx_done_tick (TX core),
//          busy/err_tick/err_code (status). slave = arbiter view, master = requester/core view.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done_tick;
  logic              busy;
  logic              err_tick;
  logic [1:0]        err_code;

  modport master (
    output req, req_data, req_last, tx_done_tick,
    input  ack, grant, tx_start, tx_din, busy, err_tick, err_code
  );

  modport slave (
    input  req, req_data, req_last, tx_done_tick,
    output ack, grant, tx_start, tx_din, busy, err_tick, err_code
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART TX core among NREQ requesters, packet-locked grant, watchdog abort.
// Latency: req sampled at edge T -> ack/tx_start/grant high in cycle T+1; all outputs registered.
// Backpressure: requesters hold req+data until their ack pulse; the core paces bytes via tx_done_tick.
// Ports  : clk, reset (async, active-high), bus (uart_tx_arbiter_if.slave).
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20000,
  localparam int CW     = $clog2(TIMEOUT + 1),
  localparam int IW     = $clog2(NREQ)
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, HOLD} state_t;

  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic            busy_q, busy_d;
  logic            err_tick_q, err_tick_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            last_q, last_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   idx;
  logic            load;
  logic            rel;
  logic [IW-1:0]   load_idx;

  // Scan ptr, ptr+1, ... (mod NREQ); the first active request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    ack_d      = '0;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    err_tick_d = 1'b0;
    err_code_d = err_code_q;
    wd_d       = wd_q;
    last_d     = last_q;
    load       = 1'b0;
    rel        = 1'b0;
    load_idx   = win_idx;

    case (state_q)
      IDLE: begin
        if (win_vld) load = 1'b1;
      end
      WAIT_DONE: begin
        // A done pulse in the timeout cycle takes priority over the abort.
        if (bus.tx_done_tick) begin
          if (last_q) begin
            rel = 1'b1;
          end else begin
            wd_d    = '0;
            state_d = HOLD;
          end
        end else if (wd_q == WD_LIMIT) begin
          rel        = 1'b1;
          err_tick_d = 1'b1;
          err_code_d = 2'b01;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HOLD: begin
        // Packet lock: only the current owner may continue.
        load_idx = owner_q;
        if (bus.req[owner_q]) begin
          load = 1'b1;
        end else if (wd_q == WD_LIMIT) begin
          rel        = 1'b1;
          err_tick_d = 1'b1;
          err_code_d = 2'b10;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      grant_d           = '0;
      grant_d[load_idx] = 1'b1;
      ack_d[load_idx]   = 1'b1;
      owner_d           = load_idx;
      tx_din_d          = bus.req_data[int'(load_idx)*8 +: 8];
      last_d            = bus.req_last[load_idx];
      tx_start_d        = 1'b1;
      wd_d              = '0;
      state_d           = WAIT_DONE;
    end

    // Release after a packet or an abort: the old owner drops to lowest priority.
    if (rel) begin
      grant_d = '0;
      ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      wd_d    = '0;
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      busy_q     <= 1'b0;
      err_tick_q <= 1'b0;
      err_code_q <= 2'b00;
      wd_q       <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      busy_q     <= busy_d;
      err_tick_q <= err_tick_d;
      err_code_q <= err_code_d;
      wd_q       <= wd_d;
      last_q     <= last_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant    = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.busy     = busy_q;
  assign bus.err_tick = err_tick_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=20).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task carries its own inline comparisons against hand-computed values.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_cnt  = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ack_cnt = ack_cnt + $countones(bus.ack);

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.req          = '0;
    bus.req_data     = '0;
    bus.req_last     = '0;
    bus.tx_done_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic l);
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]        = l;
    bus.req[i]             = 1'b1;
  endtask

  // Called at t = edge+1; returns the number of falling edges before tx_start, or -1.
  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        cyc = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.req          = 4'b1111;
    bus.req_data     = 32'hFFFF_FFFF;
    bus.req_last     = 4'b1111;
    bus.tx_done_tick = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({bus.ack, bus.grant} !== 8'h00) begin n_fail++; $display("FAIL reset_ack_grant: got %h want 00", {bus.ack, bus.grant}); end
    n_checks++; if ({bus.tx_start, bus.tx_din} !== 9'h000) begin n_fail++; $display("FAIL reset_tx: got %h want 000", {bus.tx_start, bus.tx_din}); end
    n_checks++; if ({bus.busy, bus.err_tick, bus.err_code} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {bus.busy, bus.err_tick, bus.err_code}); end
    bus.req = '0;
    bus.tx_done_tick = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int cyc;
    do_reset();
    set_byte(2, 8'hA5, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b want 0", bus.tx_start); end
    step();
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", bus.tx_start); end
    n_checks++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", bus.ack); end
    n_checks++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
    n_checks++; if (bus.tx_din !== 8'hA5) begin n_fail++; $display("FAIL single_din: got %h want a5", bus.tx_din); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    step();
    @(negedge clk);
    n_checks++; if ({bus.tx_start, bus.ack, bus.grant} !== 9'b0_0000_0100) begin n_fail++; $display("FAIL single_pulse_end: got %b want 000000100", {bus.tx_start, bus.ack, bus.grant}); end
    step();
    pulse_done();
    @(negedge clk);
    n_checks++; if ({bus.grant, bus.busy} !== 5'b0000_0) begin n_fail++; $display("FAIL single_release: got %b want 00000", {bus.grant, bus.busy}); end
    step();
    // Pointer now sits at 3, so requester 3 beats requester 0.
    set_byte(0, 8'h10, 1'b1);
    set_byte(3, 8'h33, 1'b1);
    wait_start(4, cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL ptr_start_latency: got %0d want 1", cyc); end
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b1000, 8'h33}) begin n_fail++; $display("FAIL ptr_winner: got %h want 833", {bus.grant, bus.tx_din}); end
    step();
    bus.req = '0;
    pulse_done();
  endtask

  task automatic test_round_robin();
    int cyc;
    int a0;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'(8'hC0 + i), 1'b1);
    a0 = ack_cnt;
    for (int n = 0; n < 5; n++) begin
      exp = 4'(1 << (n % 4));
      wait_start(8, cyc);
      n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL rr_start_%0d: got no tx_start want one", n); end
      n_checks++; if (bus.grant !== exp) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", n, bus.grant, exp); end
      n_checks++; if (bus.ack !== exp) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", n, bus.ack, exp); end
      n_checks++; if (bus.tx_din !== 8'(8'hC0 + (n % 4))) begin n_fail++; $display("FAIL rr_din_%0d: got %h want %h", n, bus.tx_din, 8'(8'hC0 + (n % 4))); end
      step();
      pulse_done();
    end
    bus.req = '0;
    step();
    step();
    n_checks++; if (ack_cnt - a0 !== 5) begin n_fail++; $display("FAIL rr_ack_count: got %0d want 5", ack_cnt - a0); end
  endtask

  task automatic test_packet_lock();
    int cyc;
    do_reset();
    set_byte(0, 8'h11, 1'b0);
    set_byte(1, 8'h77, 1'b1);
    wait_start(4, cyc);
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0001, 8'h11}) begin n_fail++; $display("FAIL lock_b0: got %h want 111", {bus.grant, bus.tx_din}); end
    step();
    bus.req_data[7:0] = 8'h22;
    pulse_done();
    @(negedge clk);
    n_checks++; if ({bus.grant, bus.busy} !== 5'b0001_1) begin n_fail++; $display("FAIL lock_hold1: got %b want 00011", {bus.grant, bus.busy}); end
    step();
    wait_start(4, cyc);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL lock_gap: got %0d want 0", cyc); end
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0001, 8'h22}) begin n_fail++; $display("FAIL lock_b1: got %h want 122", {bus.grant, bus.tx_din}); end
    step();
    bus.req_data[7:0] = 8'h33;
    bus.req_last[0]   = 1'b1;
    pulse_done();
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL lock_hold2: got %b want 0001", bus.grant); end
    step();
    wait_start(4, cyc);
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0001, 8'h33}) begin n_fail++; $display("FAIL lock_b2: got %h want 133", {bus.grant, bus.tx_din}); end
    step();
    bus.req[0] = 1'b0;
    pulse_done();
    wait_start(4, cyc);
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0010, 8'h77}) begin n_fail++; $display("FAIL lock_next_owner: got %h want 277", {bus.grant, bus.tx_din}); end
    step();
    bus.req = '0;
    pulse_done();
  endtask

  task automatic test_done_timeout();
    int cyc;
    int n;
    do_reset();
    set_byte(1, 8'h5A, 1'b1);
    set_byte(2, 8'hB2, 1'b1);
    wait_start(4, cyc);
    n_checks++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL dto_grant: got %b want 0010", bus.grant); end
    bus.req[1] = 1'b0;
    n = -1;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      step();
      @(negedge clk);
      if (bus.err_tick === 1'b1) begin
        n = k;
        break;
      end
    end
    n_checks++; if (n !== TIMEOUT) begin n_fail++; $display("FAIL dto_delay: got %0d want %0d", n, TIMEOUT); end
    n_checks++; if (bus.err_code !== 2'b01) begin n_fail++; $display("FAIL dto_code: got %b want 01", bus.err_code); end
    n_checks++; if ({bus.grant, bus.busy} !== 5'b0000_0) begin n_fail++; $display("FAIL dto_release: got %b want 00000", {bus.grant, bus.busy}); end
    step();
    wait_start(4, cyc);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL dto_next_latency: got %0d want 0", cyc); end
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0100, 8'hB2}) begin n_fail++; $display("FAIL dto_next: got %h want 4b2", {bus.grant, bus.tx_din}); end
    n_checks++; if ({bus.err_tick, bus.err_code} !== 3'b001) begin n_fail++; $display("FAIL dto_code_hold: got %b want 001", {bus.err_tick, bus.err_code}); end
    step();
    bus.req = '0;
    pulse_done();
  endtask

  task automatic test_hold_timeout();
    int cyc;
    int n;
    do_reset();
    set_byte(0, 8'h44, 1'b0);
    wait_start(4, cyc);
    bus.req[0] = 1'b0;
    step();
    pulse_done();
    n = -1;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      step();
      @(negedge clk);
      if (bus.err_tick === 1'b1) begin
        n = k;
        break;
      end
    end
    n_checks++; if (n !== TIMEOUT) begin n_fail++; $display("FAIL hto_delay: got %0d want %0d", n, TIMEOUT); end
    n_checks++; if (bus.err_code !== 2'b10) begin n_fail++; $display("FAIL hto_code: got %b want 10", bus.err_code); end
    n_checks++; if ({bus.grant, bus.busy} !== 5'b0000_0) begin n_fail++; $display("FAIL hto_release: got %b want 00000", {bus.grant, bus.busy}); end
    step();
    set_byte(0, 8'h45, 1'b1);
    set_byte(1, 8'h55, 1'b1);
    wait_start(4, cyc);
    n_checks++; if ({bus.grant, bus.tx_din} !== {4'b0010, 8'h55}) begin n_fail++; $display("FAIL hto_ptr: got %h want 255", {bus.grant, bus.tx_din}); end
    step();
    bus.req = '0;
    pulse_done();
  endtask

  task automatic test_done_at_timeout();
    int cyc;
    bit saw_err;
    do_reset();
    set_byte(3, 8'h99, 1'b1);
    wait_start(4, cyc);
    bus.req[3] = 1'b0;
    repeat (TIMEOUT - 1) step();
    pulse_done();
    @(negedge clk);
    n_checks++; if ({bus.err_tick, bus.grant, bus.busy} !== 6'b0_0000_0) begin n_fail++; $display("FAIL edge_done_release: got %b want 000000", {bus.err_tick, bus.grant, bus.busy}); end
    saw_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      if (bus.err_tick !== 1'b0) saw_err = 1'b1;
    end
    n_checks++; if ({saw_err, bus.err_code} !== 3'b000) begin n_fail++; $display("FAIL edge_done_no_err: got %b want 000", {saw_err, bus.err_code}); end
    step();
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    do_reset();
    set_byte(2, 8'hD4, 1'b0);
    wait_start(4, cyc);
    bus.req = '0;
    step();
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.grant, bus.busy, bus.ack, bus.tx_start} !== 10'h000) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000000000", {bus.grant, bus.busy, bus.ack, bus.tx_start}); end
    n_checks++; if ({bus.tx_din, bus.err_tick, bus.err_code} !== 11'h000) begin n_fail++; $display("FAIL rst_mid_data: got %h want 000", {bus.tx_din, bus.err_tick, bus.err_code}); end
    @(posedge clk);
    #1 reset = 1'b0;
    set_byte(3, 8'hE7, 1'b1);
    wait_start(4, cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 1", cyc); end
    n_checks++; if ({bus.grant, bus.ack, bus.tx_din} !== {4'b1000, 4'b1000, 8'hE7}) begin n_fail++; $display("FAIL rst_after_serve: got %h want 88e7", {bus.grant, bus.ack, bus.tx_din}); end
    step();
    bus.req = '0;
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_done_timeout();
    test_hold_timeout();
    test_done_at_timeout();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
